// File: rtl/ram_arbiter.sv
// Two-port front end for a single-port synchronous RAM. Port A is the CPU (read/write)
// and port B is video fetch (read-only). Define RAM_ARB_RR_EN to get round-robin conflict arbitration.
module ram_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     a_req_i,
  input  logic                     a_we_i,
  input  logic [ADDRESS_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0]    a_wdata_i,
  output logic                     a_ack_o,
  output logic [DATA_WIDTH-1:0]    a_rdata_o,
  input  logic                     b_req_i,
  input  logic [ADDRESS_WIDTH-1:0] b_addr_i,
  output logic                     b_ack_o,
  output logic [DATA_WIDTH-1:0]    b_rdata_o,
  output logic                     ram_we_o,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_din_o,
  input  logic [DATA_WIDTH-1:0]    ram_dout_i
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate any request
  // ACCESS | RAM samples registered addr/we/din at the end of this cycle
  // RESP   | RAM dout valid; ack granted port, hand off to the other port if it waits
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_e                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       ram_we_q, ram_we_d;
  logic [ADDRESS_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]      ram_din_q, ram_din_d;
  logic                       load_a, load_b;
`ifdef RAM_ARB_RR_EN
  logic                       last_q, last_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
`ifdef RAM_ARB_RR_EN
    last_d     = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (a_req_i && b_req_i) begin
`ifdef RAM_ARB_RR_EN
          // Only genuine conflicts move the round-robin pointer.
          if (last_q == GNT_B) begin
            load_a = 1'b1;
            last_d = GNT_A;
          end else begin
            load_b = 1'b1;
            last_d = GNT_B;
          end
`else
          load_b = 1'b1;
`endif
        end else if (a_req_i) begin
          load_a = 1'b1;
        end else if (b_req_i) begin
          load_b = 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        // The port being acked this cycle is not eligible again until IDLE.
        if (grant_q == GNT_A && b_req_i) begin
          load_b = 1'b1;
        end else if (grant_q == GNT_B && a_req_i) begin
          load_a = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_a) begin
      state_d    = S_ACCESS;
      grant_d    = GNT_A;
      ram_we_d   = a_we_i;
      ram_addr_d = a_addr_i;
      ram_din_d  = a_wdata_i;
    end else if (load_b) begin
      state_d    = S_ACCESS;
      grant_d    = GNT_B;
      ram_we_d   = 1'b0;
      ram_addr_d = b_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      grant_q    <= GNT_B;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      last_q <= GNT_B;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign a_ack_o    = (state_q == S_RESP) && (grant_q == GNT_A);
  assign b_ack_o    = (state_q == S_RESP) && (grant_q == GNT_B);
  assign a_rdata_o  = ram_dout_i;
  assign b_rdata_o  = ram_dout_i;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural single-port RAM (1-cycle registered read).
// Expected ack cycles and data are hand-computed per directed scenario.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [13:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        b_req = 1'b0;
  logic [13:0] b_addr = '0;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:16383];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(14)) dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .a_req_i    (a_req),
    .a_we_i     (a_we),
    .a_addr_i   (a_addr),
    .a_wdata_i  (a_wdata),
    .a_ack_o    (a_ack),
    .a_rdata_o  (a_rdata),
    .b_req_i    (b_req),
    .b_addr_i   (b_addr),
    .b_ack_o    (b_ack),
    .b_rdata_o  (b_rdata),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_a(input logic rd, input logic [7:0] d, input int c);
    exp_t e;
    e.rd = rd; e.data = d; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input int c);
    exp_t e;
    e.rd = 1'b1; e.data = d; e.cyc = c;
    qb.push_back(e);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (a_ack) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_ack", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_ack_cycle", cyc, e.cyc);
          if (e.rd) chk("a_rdata", int'(a_rdata), int'(e.data));
        end
      end
      if (b_ack) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_ack", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_ack_cycle", cyc, e.cyc);
          chk("b_rdata", int'(b_rdata), int'(e.data));
        end
      end
    end
  end

  task automatic wait_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ack && n < 20);
    if (!a_ack) chk("a_ack_timeout", 0, 1);
  endtask

  task automatic wait_b();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_ack && n < 20);
    if (!b_ack) chk("b_ack_timeout", 0, 1);
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic a_do(input logic we, input logic [13:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp, input int lat);
    push_a(!we, exp, cyc + lat);
    a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    wait_a();
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic b_do(input logic [13:0] addr, input logic [7:0] exp, input int lat);
    push_b(exp, cyc + lat);
    b_addr = addr; b_req = 1'b1;
    wait_b();
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  task automatic a_hold3(input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2);
    a_we = 1'b0; a_addr = a0; a_req = 1'b1;
    wait_a();
    @(posedge clk); #1; a_addr = a1;
    wait_a();
    @(posedge clk); #1; a_addr = a2;
    wait_a();
    @(posedge clk); #1; a_req = 1'b0;
  endtask

  task automatic b_hold3(input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2);
    b_addr = a0; b_req = 1'b1;
    wait_b();
    @(posedge clk); #1; b_addr = a1;
    wait_b();
    @(posedge clk); #1; b_addr = a2;
    wait_b();
    @(posedge clk); #1; b_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ram_we"},   int'(ram_we),   0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_ram_din"},  int'(ram_din),  0);
    chk({tag, "_a_ack"},    int'(a_ack),    0);
    chk({tag, "_b_ack"},    int'(b_ack),    0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pa [10];
    logic [7:0]  pd [10];
    int w0;
    int t0;

    pa = '{14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0100,
           14'h0200, 14'h0101, 14'h0201, 14'h0300, 14'h0400};
    pd = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h77, 8'h88, 8'h66, 8'h55, 8'h99, 8'h44};

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // A write then A read of the same word; exactly one ram_we cycle for the write.
    w0 = we_cnt;
    a_do(1'b1, 14'h1234, 8'h5A, 8'h00, 2);
    chk("t1_write_we_cycles", we_cnt - w0, 1);
    w0 = we_cnt;
    a_do(1'b0, 14'h1234, 8'h00, 8'h5A, 2);
    chk("t1_read_we_cycles", we_cnt - w0, 0);

    for (int i = 0; i < 10; i++) a_do(1'b1, pa[i], pd[i], 8'h00, 2);
    for (int i = 0; i < 10; i++) chk("preload_mem", int'(mem[pa[i]]), int'(pd[i]));

    w0 = we_cnt;
    b_do(14'h0000, 8'hC3, 2);
    chk("t2_b_we_cycles", we_cnt - w0, 0);

    // Simultaneous requests.
`ifdef RAM_ARB_RR_EN
    fork
      a_do(1'b0, 14'h0100, 8'h00, 8'h77, 2);
      b_do(14'h0200, 8'h88, 4);
    join
    fork
      a_do(1'b0, 14'h0101, 8'h00, 8'h66, 4);
      b_do(14'h0201, 8'h55, 2);
    join
`else
    fork
      a_do(1'b0, 14'h0100, 8'h00, 8'h77, 4);
      b_do(14'h0200, 8'h88, 2);
    join
    fork
      a_do(1'b0, 14'h0101, 8'h00, 8'h66, 4);
      b_do(14'h0201, 8'h55, 2);
    join
`endif

    // A holds req across three reads: the ack cycle is ineligible, so acks are 3 apart.
    t0 = cyc;
    push_a(1'b1, 8'h11, t0 + 2);
    push_a(1'b1, 8'h22, t0 + 5);
    push_a(1'b1, 8'h33, t0 + 8);
    a_hold3(14'h0001, 14'h0002, 14'h0003);

    // B streams while A arrives during B's first access: hand-off in RESP both ways.
    t0 = cyc;
    push_b(8'h99, t0 + 2);
    push_b(8'h11, t0 + 6);
    push_b(8'h22, t0 + 9);
    fork
      b_hold3(14'h0300, 14'h0001, 14'h0002);
      begin
        @(posedge clk); #1;
        a_do(1'b0, 14'h0400, 8'h00, 8'h44, 3);
      end
    join

    // Reset asserted during the ACCESS cycle of an A write.
    a_we = 1'b1; a_addr = 14'h0010; a_wdata = 8'hFF; a_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_access_ram_we", int'(ram_we), 1);
    chk("t5_access_ram_addr", int'(ram_addr), 16'h0010);
    resetn = 1'b0;
    @(posedge clk); #1;
    a_req = 1'b0;
    chk_reset_outputs("t5_reset");
    chk("t5_mem_committed", int'(mem[14'h0010]), 8'hFF);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_late_ack_a", int'(a_ack), 0);
    chk("t5_idle_we", int'(ram_we), 0);
    a_do(1'b0, 14'h0010, 8'h00, 8'hFF, 2);

    // After reset the round-robin pointer is back to B, so A wins first.
`ifdef RAM_ARB_RR_EN
    fork
      a_do(1'b0, 14'h0002, 8'h00, 8'h22, 2);
      b_do(14'h0003, 8'h33, 4);
    join
`else
    fork
      a_do(1'b0, 14'h0002, 8'h00, 8'h22, 4);
      b_do(14'h0003, 8'h33, 2);
    join
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
